io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the single memory-mapped IO register bus (io_write_en/io_read_en/io_address/io_write_data/io_read_data)
//  between NUM_REQ requesters, e.g. core IO port and JTAG debug host. Round-robin arbitration, one transaction
//  in flight, fixed-latency read return. Sits between requesters and the IO register decode in fpga_top.
// PARAMETERS
//  NUM_REQ        2   number of requesters, 1..8
//  READ_LATENCY   0   cycles from io_read_en to valid io_read_data, 0..15
// PORTS
//  clk             in   1           system clock; all logic rising-edge
//  reset_n         in   1           asynchronous, active-low reset
//  req_valid       in   NUM_REQ     per-requester request; hold with payload stable until req_ack
//  req_write       in   NUM_REQ     1=write, 0=read
//  req_address     in   NUM_REQ*32  requester i at [32*i+:32]
//  req_write_data  in   NUM_REQ*32  requester i at [32*i+:32]
//  req_lock        in   NUM_REQ     keep grant for next transaction (present only with IO_ARB_LOCK_EN)
//  req_ack         out  NUM_REQ     one-cycle completion pulse, one-hot to granted requester
//  resp_read_data  out  32          read data, valid in req_ack cycle of a read
//  grant_id        out  $clog2(NUM_REQ) (min 1)  index of current/last granted requester
//  io_write_en     out  1           one-cycle write strobe
//  io_read_en      out  1           one-cycle read strobe
//  io_address      out  32          registered, held from issue until next issue
//  io_write_data   out  32          registered, held from issue until next issue
//  io_read_data    in   32          read data from IO decode
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, FSM=IDLE, rr pointer so requester 0 wins first. Reset mid-transaction
//    aborts it with no req_ack; strobes drop immediately.
//  - FSM: IDLE -> ISSUE -> (write) IDLE ; (read) WAIT -> RESP -> IDLE.
//  - IDLE: if any req_valid, pick first valid at or after rr pointer (wrap NUM_REQ-1 -> 0); latch grant_id,
//    address, data, write flag; go ISSUE. Pointer := winner+1 mod NUM_REQ. No valid: stay IDLE, outputs quiet.
//  - ISSUE (1 cycle): exactly one of io_write_en/io_read_en high. Write: req_ack[grant] pulses this cycle -> IDLE.
//    Read: READ_LATENCY=0 -> sample io_read_data this cycle -> RESP; else -> WAIT.
//  - WAIT: counter counts READ_LATENCY cycles; sample io_read_data on cycle io_read_en+READ_LATENCY -> RESP.
//  - RESP (1 cycle): resp_read_data=sampled value, req_ack[grant] pulses -> IDLE.
//  - Latency, request seen in IDLE at cycle t: write strobe+ack at t+1; read strobe t+1, ack t+2+READ_LATENCY.
//  - Max throughput: one write per 2 cycles; req_valid still high in cycle after ack is a NEW request.
//  - Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 transactions.
//  - req_valid dropped before ack: protocol violation; transaction still completes, ack still issued.
//  - resp_read_data holds last read value until next RESP; 0 after reset. NUM_REQ=1: grant_id constant 0.
// CONFIGURATION
//  IO_ARB_LOCK_EN defined: req_lock port present; if granted requester has req_lock=1 in its ack cycle, rr
//    pointer is not advanced past it and it wins the next IDLE evaluation if req_valid=1 (atomic RMW sequences).
//    Lock released when req_lock=0 at ack or req_valid=0 in IDLE.
//  IO_ARB_LOCK_EN undefined: no req_lock port; pure round-robin.
// TESTING
//  1. Reset low, req_valid=2'b11 -> all outputs 0, no strobes; release -> req 0 granted first (grant_id=0).
//  2. Req0 write addr 0x8 data 0x7F -> io_write_en 1 cycle at t+1 with addr 0x8/data 0x7F, req_ack=2'b01 same cycle.
//  3. READ_LATENCY=2, req1 read addr 0x14, io_read_data=0xDEADBEEF at strobe+2 -> req_ack=2'b10 at t+4,
//     resp_read_data=0xDEADBEEF.
//  4. Both requesters hold writes continuously -> grants alternate 0,1,0,1; strobes every 2 cycles.
//  5. Read in WAIT, reset_n pulsed low -> strobes/acks 0 at once, no ack after release, FSM IDLE.
//  6. IO_ARB_LOCK_EN: req0 req_lock=1 for 3 writes while req1 requests -> 3 consecutive grants to 0, then 1.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// Bundles the requester handshake and the IO register bus of io_bus_arbiter.
// Ports: req_valid/req_write/req_address/req_write_data/req_ack/resp_read_data/grant_id
//        from requesters, io_write_en/io_read_en/io_address/io_write_data/io_read_data to IO decode.
// IO_ARB_LOCK_EN: when defined, adds the per-requester req_lock signal.
interface io_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_address;
  logic [NUM_REQ*32-1:0] req_write_data;
`ifdef IO_ARB_LOCK_EN
  logic [NUM_REQ-1:0]    req_lock;
`endif
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           resp_read_data;
  logic [GID_W-1:0]      grant_id;
  logic                  io_write_en;
  logic                  io_read_en;
  logic [31:0]           io_address;
  logic [31:0]           io_write_data;
  logic [31:0]           io_read_data;

  // Arbiter side.
  modport slave (
`ifdef IO_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_write, req_address, req_write_data, io_read_data,
    output req_ack, resp_read_data, grant_id,
    output io_write_en, io_read_en, io_address, io_write_data
  );

  // Requester / IO decode side.
  modport master (
`ifdef IO_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_write, req_address, req_write_data, io_read_data,
    input  req_ack, resp_read_data, grant_id,
    input  io_write_en, io_read_en, io_address, io_write_data
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one IO register bus between NUM_REQ requesters, one transaction in flight.
// Latency: request seen in IDLE at t -> strobe at t+1; write ack t+1, read ack t+2+READ_LATENCY.
// Backpressure: requesters hold req_valid/payload until their one-cycle req_ack; others wait their turn.
// Ports: clk, reset_n (async active-low), bus (io_bus_arbiter_if.slave: requester handshake + IO bus).
// IO_ARB_LOCK_EN: when defined, a granted requester holding req_lock at ack keeps the round-robin pointer.
module io_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 0
) (
  input logic               clk,
  input logic               reset_n,
  io_bus_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q;
  logic [PTR_W-1:0]   winner;
  logic               any_vld;
  logic               wr_q;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, wdat_q, rdat_q;
  logic               latch_en;
  logic               sample_en;
  logic               ack_en;

  // First valid requester at or after the rr pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int j;
    any_vld = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_vld && bus.req_valid[PTR_W'(j)]) begin
        any_vld = 1'b1;
        winner  = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    sample_en = 1'b0;
    ack_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          latch_en = 1'b1;
          rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          ack_en  = 1'b1;
          state_d = IDLE;
        end else if (READ_LATENCY == 0) begin
          sample_en = 1'b1;
          state_d   = RESP;
        end else begin
          // cnt tracks cycles elapsed since the read strobe.
          cnt_d   = 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(READ_LATENCY)) begin
          sample_en = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        ack_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef IO_ARB_LOCK_EN
    // Pointing back at the holder makes it win the next evaluation if still valid;
    // if it has gone idle the scan simply moves on, which releases the lock.
    if (ack_en && bus.req_lock[grant_q]) rr_ptr_d = grant_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (latch_en) begin
        grant_q <= winner;
        wr_q    <= bus.req_write[winner];
        addr_q  <= bus.req_address[32*winner +: 32];
        wdat_q  <= bus.req_write_data[32*winner +: 32];
      end
      if (sample_en) rdat_q <= bus.io_read_data;
    end
  end

  // Strobes and acks decode the state register, so an async reset kills them immediately.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ack[i] = ack_en && (grant_q == PTR_W'(i));
    end
  end

  assign bus.io_write_en    = (state_q == ISSUE) && wr_q;
  assign bus.io_read_en     = (state_q == ISSUE) && !wr_q;
  assign bus.io_address     = addr_q;
  assign bus.io_write_data  = wdat_q;
  assign bus.resp_read_data = rdat_q;
  assign bus.grant_id       = grant_q;
endmodule
